// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types and constants.
// State enum, port IDs and default RAM geometry.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arbiter winner select (one-hot, bit index = port ID).
// MEM_ARB_RR_EN: ties go to the pointer's port; else CPU first.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_cpu_req,
  input  logic       i_ld_req,
  input  logic       i_rr_ptr,
  output logic [1:0] o_win
);

`ifdef MEM_ARB_RR_EN
  // Tie broken by pointer; lone requester wins at once
  always_comb begin
    o_win = '0;
    if (i_cpu_req && i_ld_req) begin
      if (i_rr_ptr) o_win[PORT_LD] = 1'b1;
      else          o_win[PORT_CPU] = 1'b1;
    end else if (i_cpu_req) begin
      o_win[PORT_CPU] = 1'b1;
    end else if (i_ld_req) begin
      o_win[PORT_LD] = 1'b1;
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = i_rr_ptr;

  // Fixed priority: loader only when CPU is quiet
  always_comb begin
    o_win = '0;
    if (i_cpu_req)     o_win[PORT_CPU] = 1'b1;
    else if (i_ld_req) o_win[PORT_LD] = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// CPU / loader arbiter for the single-port data RAM.
// Optional round-robin tie break with MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_issue;
  logic [1:0]        w_win;
  logic              w_sel_ld;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_rr_ptr;

  logic              r_owner;
  logic              r_read;
  logic              r_cpu_gnt;
  logic              r_ld_gnt;
  logic              r_cpu_rvalid;
  logic              r_ld_rvalid;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;

`ifdef MEM_ARB_RR_EN
  logic r_rr_ptr;

  // Pointer names the port preferred on the next tie
  always_ff @(posedge clk) begin
    if (!rst_n)       r_rr_ptr <= PORT_CPU;
    else if (w_issue) r_rr_ptr <= ~w_sel_ld;
  end

  assign w_rr_ptr = r_rr_ptr;
`else
  assign w_rr_ptr = 1'b0;
`endif

  mem_arb_pick u_pick (
    .i_cpu_req (cpu_req),
    .i_ld_req  (ld_req),
    .i_rr_ptr  (w_rr_ptr),
    .o_win     (w_win)
  );

  assign w_sel_ld = w_win[PORT_LD];
  assign w_we     = w_sel_ld ? ld_we    : cpu_we;
  assign w_addr   = w_sel_ld ? ld_addr  : cpu_addr;
  assign w_wdata  = w_sel_ld ? ld_wdata : cpu_wdata;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: issue from IDLE, ACCESS always lasts one cycle
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cpu_req || ld_req) begin
          w_issue     = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: w_state_nxt = IDLE;
    endcase
  end

  // Registered strobes, grants, read returns and ownership
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner      <= PORT_CPU;
      r_read       <= 1'b0;
      r_cpu_gnt    <= 1'b0;
      r_ld_gnt     <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_ld_rvalid  <= 1'b0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
    end else begin
      r_cpu_gnt    <= 1'b0;
      r_ld_gnt     <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_ld_rvalid  <= 1'b0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      if (w_issue) begin
        r_ram_en    <= 1'b1;
        r_ram_we    <= w_we;
        r_ram_addr  <= w_addr;
        r_ram_wdata <= w_wdata;
        r_cpu_gnt   <= w_win[PORT_CPU];
        r_ld_gnt    <= w_win[PORT_LD];
        r_owner     <= w_sel_ld;
        r_read      <= ~w_we;
      end
      if (r_state == ACCESS && r_read) begin
        if (r_owner == PORT_LD) r_ld_rvalid  <= 1'b1;
        else                    r_cpu_rvalid <= 1'b1;
      end
    end
  end

  assign cpu_gnt    = r_cpu_gnt;
  assign ld_gnt     = r_ld_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign ld_rvalid  = r_ld_rvalid;
  assign cpu_rdata  = ram_rdata;
  assign ld_rdata   = ram_rdata;
  assign cpu_stall  = cpu_req && !r_cpu_gnt;
  assign ram_en     = r_ram_en;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Builds with or without MEM_ARB_RR_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_stall;
  logic [15:0] cpu_rdata;
  logic        ld_req, ld_we;
  logic [7:0]  ld_addr;
  logic [15:0] ld_wdata;
  logic        ld_gnt, ld_rvalid;
  logic [15:0] ld_rdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;

  logic [15:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .ld_req     (ld_req),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_gnt     (ld_gnt),
    .ld_rvalid  (ld_rvalid),
    .ld_rdata   (ld_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
    tick(); tick();
    n_checks++;
    if ({cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: got %b expected 0000",
               {cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid});
    end
    n_checks++;
    if ({ram_en, ram_we} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 00", {ram_en, ram_we});
    end
    n_checks++;
    if ({ram_addr, ram_wdata} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_addr_data: got %h expected 000000",
               {ram_addr, ram_wdata});
    end
    n_checks++;
    if (cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: got %b expected 0", cpu_stall);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10; cpu_wdata = 16'hAAAA;
    #1;
    n_checks++;
    if (cpu_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_stall_wait: got %b expected 1", cpu_stall);
    end
    tick();
    n_checks++;
    if ({cpu_gnt, ld_gnt, ram_en, ram_we} !== 4'b1010) begin
      n_fail++;
      $display("FAIL rd_grant: gnt/lgnt/en/we got %b expected 1010",
               {cpu_gnt, ld_gnt, ram_en, ram_we});
    end
    n_checks++;
    if (ram_addr !== 8'h10) begin
      n_fail++;
      $display("FAIL rd_addr: got %h expected 10", ram_addr);
    end
    n_checks++;
    if (cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_stall_gnt: got %b expected 0", cpu_stall);
    end
    cpu_req = 0;
    tick();
    n_checks++;
    if ({cpu_rvalid, ld_rvalid, cpu_gnt, ram_en} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rd_rvalid: rv/lrv/gnt/en got %b expected 1000",
               {cpu_rvalid, ld_rvalid, cpu_gnt, ram_en});
    end
    n_checks++;
    if (cpu_rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rd_data: got %h expected beef", cpu_rdata);
    end
    tick();
    n_checks++;
    if (cpu_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_rvalid_drop: got %b expected 0", cpu_rvalid);
    end
  endtask

  task automatic test_ld_write_cpu_read();
    ld_req = 1; ld_we = 1; ld_addr = 8'h20; ld_wdata = 16'h1234;
    tick();
    n_checks++;
    if ({ld_gnt, cpu_gnt, ram_en, ram_we} !== 4'b1011) begin
      n_fail++;
      $display("FAIL wr_grant: lgnt/gnt/en/we got %b expected 1011",
               {ld_gnt, cpu_gnt, ram_en, ram_we});
    end
    n_checks++;
    if ({ram_addr, ram_wdata} !== 24'h201234) begin
      n_fail++;
      $display("FAIL wr_addr_data: got %h expected 201234",
               {ram_addr, ram_wdata});
    end
    ld_req = 0;
    tick();
    n_checks++;
    if ({ram_we, ram_en, ld_rvalid, cpu_rvalid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL wr_after: we/en/lrv/rv got %b expected 0000",
               {ram_we, ram_en, ld_rvalid, cpu_rvalid});
    end
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
    tick();
    cpu_req = 0;
    tick();
    n_checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'h1234}) begin
      n_fail++;
      $display("FAIL wr_readback: rv/data got %b/%h expected 1/1234",
               cpu_rvalid, cpu_rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    bit rr;
    bit e_cg, e_lg, e_crv, e_lrv, last_cpu;
    int g;
`ifdef MEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst_n = 0;
    tick();
    rst_n = 1;
    last_cpu = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    ld_req  = 1; ld_we  = 0; ld_addr  = 8'h20;
    for (int k = 1; k <= 16; k++) begin
      tick();
      g     = (k - 1) / 2;
      e_cg  = (k % 2 == 1) && (!rr || (g % 2 == 0));
      e_lg  = (k % 2 == 1) && !e_cg;
      e_crv = (k % 2 == 0) && last_cpu;
      e_lrv = (k % 2 == 0) && !last_cpu;
      n_checks++;
      if ({cpu_gnt, ld_gnt} !== {e_cg, e_lg}) begin
        n_fail++;
        $display("FAIL arb_gnt[%0d]: cpu/ld got %b%b expected %b%b",
                 k, cpu_gnt, ld_gnt, e_cg, e_lg);
      end
      n_checks++;
      if (cpu_stall !== !e_cg) begin
        n_fail++;
        $display("FAIL arb_stall[%0d]: got %b expected %b",
                 k, cpu_stall, !e_cg);
      end
      n_checks++;
      if ({cpu_rvalid, ld_rvalid} !== {e_crv, e_lrv}) begin
        n_fail++;
        $display("FAIL arb_rvalid[%0d]: cpu/ld got %b%b expected %b%b",
                 k, cpu_rvalid, ld_rvalid, e_crv, e_lrv);
      end
      if (k % 2 == 0) begin
        n_checks++;
        if (cpu_rdata !== (last_cpu ? 16'hBEEF : 16'h1234)) begin
          n_fail++;
          $display("FAIL arb_data[%0d]: got %h expected %h", k, cpu_rdata,
                   last_cpu ? 16'hBEEF : 16'h1234);
        end
      end
      if (k % 2 == 1) last_cpu = e_cg;
    end
    cpu_req = 0;
    ld_req  = 0;
    tick(); tick();
  endtask

  task automatic test_reset_in_access();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    tick();
    rst_n = 0;
    cpu_req = 0;
    tick();
    n_checks++;
    if ({cpu_rvalid, ld_rvalid, cpu_gnt, ld_gnt, ram_en, ram_we} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_acc_ctl: got %b expected 000000",
               {cpu_rvalid, ld_rvalid, cpu_gnt, ld_gnt, ram_en, ram_we});
    end
    n_checks++;
    if ({ram_addr, ram_wdata} !== 24'h0) begin
      n_fail++;
      $display("FAIL rst_acc_bus: got %h expected 000000",
               {ram_addr, ram_wdata});
    end
    rst_n = 1;
    cpu_req = 1;
    tick();
    n_checks++;
    if ({cpu_gnt, ram_en, ram_addr} !== {2'b11, 8'h10}) begin
      n_fail++;
      $display("FAIL rst_acc_regnt: gnt/en/addr got %b%b/%h expected 11/10",
               cpu_gnt, ram_en, ram_addr);
    end
    cpu_req = 0;
    tick();
    n_checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL rst_acc_rdata: rv/data got %b/%h expected 1/beef",
               cpu_rvalid, cpu_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 16'h5555;
    tick();
    n_checks++;
    if ({cpu_gnt, ram_we} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_cpu_gnt: gnt/we got %b expected 11",
               {cpu_gnt, ram_we});
    end
    cpu_req = 0;
    ld_req = 1; ld_we = 0; ld_addr = 8'h30;
    tick();
    n_checks++;
    if ({ld_gnt, ram_en, cpu_rvalid} !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_wait: lgnt/en/rv got %b expected 000",
               {ld_gnt, ram_en, cpu_rvalid});
    end
    tick();
    n_checks++;
    if ({ld_gnt, ram_en, ram_we, ram_addr} !== {3'b110, 8'h30}) begin
      n_fail++;
      $display("FAIL b2b_ld_gnt: lgnt/en/we/addr got %b%b%b/%h expected 110/30",
               ld_gnt, ram_en, ram_we, ram_addr);
    end
    ld_req = 0;
    tick();
    n_checks++;
    if ({ld_rvalid, cpu_rvalid, ld_rdata} !== {2'b10, 16'h5555}) begin
      n_fail++;
      $display("FAIL b2b_ld_data: lrv/rv/data got %b%b/%h expected 10/5555",
               ld_rvalid, cpu_rvalid, ld_rdata);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'hBEEF;
    test_reset();
    test_cpu_read();
    test_ld_write_cpu_read();
    test_contention();
    test_reset_in_access();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
